// File: rtl/dmem_responder.sv
// Data-memory slave for the multi-cycle RV32 core: serialised loads/stores with
// programmable wait states, byte-lane writes, load extension and error reporting.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dmem_rd,
  input  logic [3:0]  dmem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  load_select,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [2:0] WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic [31:0] a_q, wd_q;
  logic [3:0]  we_q;
  logic [2:0]  ls_q;
  logic        st_q, both_q;

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic                  req;
  logic                  oor, lanes_bad, ls_bad, mis, err_c, mem_wr;
  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]           word, ext;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  assign req  = dmem_rd | (|dmem_we);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (cnt == 3'd0) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture and wait counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      a_q    <= '0;
      wd_q   <= '0;
      we_q   <= '0;
      ls_q   <= '0;
      st_q   <= 1'b0;
      both_q <= 1'b0;
    end else if (state == IDLE && req) begin
      cnt    <= WS_INIT;
      a_q    <= addr;
      wd_q   <= wdata;
      we_q   <= dmem_we;
      ls_q   <= load_select;
      st_q   <= |dmem_we;
      both_q <= dmem_rd & (|dmem_we);
    end else if (state == WAIT && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  always_comb begin
    oor = |(a_q >> (ADDR_WIDTH + 2));
    case (we_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: lanes_bad = 1'b0;
      default:                   lanes_bad = 1'b1;
    endcase
    case (ls_q)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ls_bad = 1'b0;
      default:                                ls_bad = 1'b1;
    endcase
    mis   = ((ls_q[1:0] == 2'b01) && a_q[0]) || ((ls_q == 3'b010) && (a_q[1:0] != 2'b00));
    err_c = oor | (st_q ? (lanes_bad | both_q) : (ls_bad | mis));
  end

  assign widx   = a_q[ADDR_WIDTH+1:2];
  // rstn gating keeps an edge sampled during reset from ever writing
  assign mem_wr = rstn && (state == ACCESS) && st_q && !err_c;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int unsigned i = 0; i < 4; i++)
        if (we_q[i]) mem[widx][8*i +: 8] <= wd_q[8*i +: 8];
    end
  end

  always_comb begin
    word     = mem[widx];
    byte_sel = 8'(word >> {a_q[1:0], 3'b000});
    half_sel = a_q[1] ? word[31:16] : word[15:0];
    case (ls_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext = {24'd0, byte_sel};
      3'b101:  ext = {16'd0, half_sel};
      default: ext = word;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= (state == ACCESS);
      err   <= (state == ACCESS) && err_c;
      if (state == ACCESS && !st_q) rdata <= err_c ? '0 : ext;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one WAIT_STATES=1 and one WAIT_STATES=0
// instance, expected responses queued at issue and compared at each ready pulse.
module tb_dmem_responder;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [1:0]       rd;
  logic [1:0][3:0]  we;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][2:0]  lsel;
  logic [1:0]       ready, err, busy;

  typedef struct {
    logic        e;
    logic [31:0] r;
    logic        ld;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_rd [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) d0 (
    .clk(clk), .rstn(rstn), .dmem_rd(rd[0]), .dmem_we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .load_select(lsel[0]), .rdata(rdata[0]), .ready(ready[0]),
    .err(err[0]), .busy(busy[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) d1 (
    .clk(clk), .rstn(rstn), .dmem_rd(rd[1]), .dmem_we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .load_select(lsel[1]), .rdata(rdata[1]), .ready(ready[1]),
    .err(err[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ls);
    rd[d] = r; we[d] = w; addr[d] = a; wdata[d] = wd; lsel[d] = ls;
  endtask

  // Inputs are driven 1 time unit after a rising edge; the next edge accepts.
  task automatic req(input int d, input logic r, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] ls, input logic exp_e,
                     input logic [31:0] exp_r, input logic intrude);
    exp_t x;
    int   lat;
    q.push_back('{e: exp_e, r: exp_r, ld: (w == 4'b0000)});
    drive(d, r, w, a, wd, ls);
    @(posedge clk); #1;
    drive(d, 1'b0, 4'b0000, '0, '0, 3'b000);
    lat = 1;
    check("busy_after_accept", 32'(busy[d]), 32'd1);
    if (intrude) drive(d, 1'b1, 4'b0000, 32'h0000_0010, '0, 3'b010);
    while (!ready[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) drive(d, 1'b0, 4'b0000, '0, '0, 3'b000);
    end
    check("latency", 32'(lat), (d == 1) ? 32'd3 : 32'd2);
    if (ready[d]) begin
      x = q.pop_front();
      check("err", 32'(err[d]), 32'(x.e));
      if (x.ld) last_rd[d] = x.r;
      check(x.ld ? "load_rdata" : "store_keeps_rdata", rdata[d], last_rd[d]);
    end else begin
      void'(q.pop_front());
    end
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(ready[d]), 32'd0);
    check("idle_after_resp", 32'(busy[d]), 32'd0);
  endtask

  initial begin
    int pulses;
    rd = '0; we = '0; addr = '0; wdata = '0; lsel = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(ready[d]), 32'd0);
      check("rst_err",   32'(err[d]),   32'd0);
      check("rst_busy",  32'(busy[d]),  32'd0);
      check("rst_rdata", rdata[d],      32'd0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;

    // word store/load
    req(1, 0, 4'b1111, 32'h10, 32'hDEADBEEF, 3'b000, 0, 0, 0);
    req(1, 1, 4'b0000, 32'h10, 0, 3'b010, 0, 32'hDEADBEEF, 0);
    // byte lanes
    req(1, 0, 4'b1111, 32'h10, 32'h11223344, 3'b000, 0, 0, 0);
    req(1, 0, 4'b0100, 32'h12, 32'h00800000, 3'b000, 0, 0, 0);
    req(1, 1, 4'b0000, 32'h10, 0, 3'b010, 0, 32'h11803344, 0);
    req(1, 1, 4'b0000, 32'h12, 0, 3'b000, 0, 32'hFFFFFF80, 0);
    req(1, 1, 4'b0000, 32'h12, 0, 3'b100, 0, 32'h00000080, 0);
    // halfwords
    req(1, 0, 4'b1111, 32'h10, 32'h80013344, 3'b000, 0, 0, 0);
    req(1, 1, 4'b0000, 32'h12, 0, 3'b001, 0, 32'hFFFF8001, 0);
    req(1, 1, 4'b0000, 32'h12, 0, 3'b101, 0, 32'h00008001, 0);
    req(1, 1, 4'b0000, 32'h11, 0, 3'b001, 1, 32'h0, 0);
    req(1, 1, 4'b0000, 32'h10, 0, 3'b000, 0, 32'h00000044, 0);
    // out of range store aliasing word 0 must not write
    req(1, 0, 4'b1111, 32'h0, 32'hCAFEF00D, 3'b000, 0, 0, 0);
    req(1, 0, 4'b1111, 32'h1000, 32'h12345678, 3'b000, 1, 0, 0);
    req(1, 1, 4'b0000, 32'h0, 0, 3'b010, 0, 32'hCAFEF00D, 0);
    req(1, 1, 4'b0000, 32'h1000, 0, 3'b010, 1, 32'h0, 0);
    // illegal lanes, rd+we collision, bad funct3, misaligned LW
    req(1, 0, 4'b0101, 32'h10, 32'hFFFFFFFF, 3'b000, 1, 0, 0);
    req(1, 1, 4'b1111, 32'h10, 32'h55555555, 3'b000, 1, 0, 0);
    req(1, 1, 4'b0000, 32'h10, 0, 3'b010, 0, 32'h80013344, 0);
    req(1, 1, 4'b0000, 32'h10, 0, 3'b011, 1, 32'h0, 0);
    req(1, 1, 4'b0000, 32'h12, 0, 3'b010, 1, 32'h0, 0);
    req(1, 1, 4'b0000, 32'h10, 0, 3'b101, 0, 32'h00003344, 0);
    // requests while busy are dropped
    req(1, 1, 4'b0000, 32'h10, 0, 3'b010, 0, 32'h80013344, 1);
    req(0, 0, 4'b1111, 32'h40, 32'h01020304, 3'b000, 0, 0, 0);
    req(0, 1, 4'b0000, 32'h40, 0, 3'b010, 0, 32'h01020304, 1);
    req(0, 1, 4'b0000, 32'h43, 0, 3'b000, 0, 32'h00000001, 0);

    // reset in WAIT aborts a store
    req(1, 0, 4'b1111, 32'h20, 32'hA5A5A5A5, 3'b000, 0, 0, 0);
    req(1, 1, 4'b0000, 32'h20, 0, 3'b010, 0, 32'hA5A5A5A5, 0);
    drive(1, 1'b0, 4'b1111, 32'h20, 32'h5A5A5A5A, 3'b000);
    @(posedge clk); #1;
    drive(1, 1'b0, 4'b0000, '0, '0, 3'b000);
    rstn = 1'b0;
    #1;
    check("midrst_ready", 32'(ready[1]), 32'd0);
    check("midrst_err",   32'(err[1]),   32'd0);
    check("midrst_busy",  32'(busy[1]),  32'd0);
    check("midrst_rdata", rdata[1],      32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready[1]) pulses++;
    end
    check("no_ready_after_abort", 32'(pulses), 32'd0);
    req(1, 1, 4'b0000, 32'h20, 0, 3'b010, 0, 32'hA5A5A5A5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
